// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the pipeline-stage skid register.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_slot.sv
// One {ctrl, data} storage slot; ctrl can be cleared independently to form a bubble.
module pipe_slot import pipe_pkg::*; #(
  parameter int                CTRL_W     = DEF_CTRL_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Data only moves on a load, so a bubble keeps its stale payload.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_ctrl <= '0;
      r_data <= PRESET_VAL;
    end else if (i_load) begin
      r_ctrl <= i_clr_ctrl ? '0 : i_ctrl;
      r_data <= i_data;
    end else if (i_clr_ctrl) begin
      r_ctrl <= '0;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer, flush and stall counter.
//   state    | meaning
//   EMPTY    | no beat held
//   BUSY     | main slot valid
//   FULL     | main and skid slots valid, upstream stalled
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                CTRL_W     = DEF_CTRL_W,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  parameter int                CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;

  assign out_valid  = (r_state != ST_EMPTY);
  assign in_ready   = r_in_ready;
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_load  = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_skid_load  = 1'b1;
          w_next_state = ST_FULL;
        end else if (w_out_fire) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_next_state     = ST_BUSY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
    // Flush discards any accepted beat and leaves both slots as bubbles.
    if (flush) begin
      w_next_state = ST_EMPTY;
      w_main_load  = 1'b0;
      w_skid_load  = 1'b0;
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n || cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .PRESET_VAL (PRESET_VAL)
  ) u_main (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_load     (w_main_load),
    .i_clr_ctrl (flush),
    .i_ctrl     (w_main_ctrl_in),
    .i_data     (w_main_data_in),
    .o_ctrl     (out_ctrl),
    .o_data     (out_data)
  );

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .PRESET_VAL (PRESET_VAL)
  ) u_skid (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_load     (w_skid_load),
    .i_clr_ctrl (flush),
    .i_ctrl     (in_ctrl),
    .i_data     (in_data),
    .o_ctrl     (w_skid_ctrl),
    .o_data     (w_skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; a CNT_W=3 twin checks counter saturation.
module tb_pipe_stage_skid;

  localparam logic [63:0] PRESET = 64'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        arst_n, flush, in_valid, out_ready, cnt_clr;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;
  logic [15:0] stall_cnt;
  logic        in_ready_s, out_valid_s;
  logic [7:0]  out_ctrl_s;
  logic [63:0] out_data_s;
  logic [2:0]  stall_cnt_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .PRESET_VAL(PRESET), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .PRESET_VAL(PRESET), .CNT_W(3)) dut_s (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 64'hA5; in_ctrl = 8'h3; out_ready = 1'b1;

    // reset and first beat
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, PRESET);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    arst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 64'hA5);
    chk("first_ctrl", out_ctrl, 8'h3);
    in_valid = 1'b0;
    tick();
    chk("first_drain", out_valid, 0);

    // streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 8'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 64'(i));
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", out_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // backpressure into skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h101; in_ctrl = 8'h11;
    tick();
    chk("bp_b1_ready", in_ready, 1);
    chk("bp_b1_data", out_data, 64'h101);
    in_data = 64'h102; in_ctrl = 8'h12;
    tick();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_data", out_data, 64'h101);
    in_data = 64'h103; in_ctrl = 8'h13;
    tick();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_data", out_data, 64'h101);
    out_ready = 1'b1;
    tick();
    chk("bp_out2", out_data, 64'h102);
    chk("bp_out2_ctrl", out_ctrl, 8'h12);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_out3", out_data, 64'h103);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);
    chk("bp_stall", stall_cnt, 2);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("bp_clr", stall_cnt, 0);

    // flush while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h201; in_ctrl = 8'hFF;
    tick();
    in_data = 64'h202;
    tick();
    chk("fl_full", in_ready, 0);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_data_hold", out_data, 64'h201);
    in_valid = 1'b1; in_data = 64'h301; in_ctrl = 8'h5; out_ready = 1'b1;
    tick();
    chk("fl_new_valid", out_valid, 1);
    chk("fl_new_data", out_data, 64'h301);
    chk("fl_new_ctrl", out_ctrl, 8'h5);
    in_valid = 1'b0;
    tick();
    chk("fl_drain", out_valid, 0);

    // stall counter and saturation
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sc_clr0", stall_cnt, 0);
    in_valid = 1'b1; in_data = 64'h401; in_ctrl = 8'h41; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("sc_start", stall_cnt, 0);
    repeat (5) tick();
    chk("sc_five", stall_cnt, 5);
    chk("sc_five_s", stall_cnt_s, 5);
    repeat (5) tick();
    chk("sc_ten", stall_cnt, 10);
    chk("sc_sat_s", stall_cnt_s, 7);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("sc_clr", stall_cnt, 0);
    chk("sc_clr_s", stall_cnt_s, 0);

    // reset while FULL
    in_valid = 1'b1; in_data = 64'h402; in_ctrl = 8'h42;
    tick();
    in_valid = 1'b0;
    chk("mr_full", in_ready, 0);
    chk("mr_stall_pre", stall_cnt, 1);
    arst_n = 1'b0; flush = 1'b1; cnt_clr = 1'b0;
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_data", out_data, PRESET);
    chk("mr_stall", stall_cnt, 0);
    arst_n = 1'b1; flush = 1'b0;
    tick();
    chk("mr_release", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register, the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB enable registers. It replaces the single `en` stall with a valid/ready handshake.
- A 2-entry skid buffer keeps `in_ready` fully registered, so no combinational ready path runs between stages.
- A synchronous flush turns held instructions into bubbles (needed for branch/jump squash).
- A saturating stall counter supports performance analysis.
- One instance sits between each pair of pipeline stages.

Parameters:
- DATA_W, 64: width of the datapath payload (operands, PC, immediate, …).
- CTRL_W, 8: width of the control payload (writeback/mem/alu bits). Forced to 0 on flush.
- PRESET_VAL, 0: reset value of the data slots.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- arst_n, in, 1: reset, synchronous, active-low; sampled only on the rising edge of clk.
- flush, in, 1: squash all held beats; synchronous.
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: stage can accept a beat; registered.
- in_ctrl, in, CTRL_W: upstream control payload.
- in_data, in, DATA_W: upstream data payload.
- out_valid, out, 1: the main slot holds a valid beat.
- out_ready, in, 1: downstream accepts a beat.
- out_ctrl, out, CTRL_W: main slot control payload.
- out_data, out, DATA_W: main slot data payload.
- cnt_clr, in, 1: clears stall_cnt.
- stall_cnt, out, CNT_W: count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshakes and storage
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Storage is a main slot and a skid slot; each slot holds {ctrl, data}.
- Reset (arst_n=0 at a clock edge)
  - state=EMPTY, in_ready=0, out_valid=0.
  - out_ctrl=0, out_data=PRESET_VAL, skid slot={0, PRESET_VAL}, stall_cnt=0.
  - Reset overrides flush, cnt_clr and all handshakes.
  - in_ready rises at the first edge after arst_n returns to 1.
- State machine
  - States: EMPTY (no beat held), BUSY (main slot valid), FULL (main and skid slots valid).
  - out_valid = (state != EMPTY), decoded from the state register only.
  - in_ready is a register; its next value is (next_state != FULL).
- Transitions (no flush)
  - EMPTY, in_fire: main<=in; go to BUSY.
  - EMPTY, no in_fire: stay EMPTY.
  - BUSY, in_fire & out_fire: main<=in; stay BUSY.
  - BUSY, in_fire only: skid<=in; go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, out_fire: main<=skid; go to BUSY. in_fire cannot occur because in_ready=0.
  - FULL, no out_fire: hold.
- Ordering: beats leave in arrival order. Latency is 1 cycle from in_fire to out_valid when the stage is empty; throughput is 1 beat/cycle.
- Flush (arst_n=1, flush=1)
  - Next state=EMPTY; in_ready<=1.
  - out_ctrl and skid ctrl<=0 (bubble); data slots hold their values.
  - Outputs in the flush cycle are unaffected. An out_fire in that cycle completes normally.
  - An in_fire in that cycle is accepted and discarded.
- Stall counter
  - Increments when out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority: stall_cnt<=0 on that edge, with no increment.
  - Flush does not affect the counter.
- Data slots are not written in any cycle where no load occurs.

Decomposition:
- Package pipe_pkg holds:
  - the state encoding localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2;
  - the common default widths.
- Sub-module pipe_slot: one {ctrl, data} storage register with synchronous active-low reset, a load input and a ctrl-clear input. It is instantiated twice (main and skid).
- The FSM, in_ready register and stall counter stay in the top module.

Test Plan:
- Reset and first beat
  - Stimulus: arst_n=0 for 3 cycles, then release with in_valid=1, in_data=64'hA5, in_ctrl=8'h3, out_ready=1.
  - Required: in_ready=0 during reset and 1 one cycle after release. Once in_ready=1, the beat is accepted and out_valid=1, out_data=64'hA5, out_ctrl=8'h3 appear on the next cycle.
- Streaming
  - Stimulus: beats 1..8 with in_valid=1 and out_ready=1 every cycle.
  - Required: outputs 1..8 in consecutive cycles, 1-cycle latency, stall_cnt=0.
- Backpressure into skid
  - Stimulus: out_ready=0 while beats 1, 2 are sent, then 3 is offered.
  - Required: state reaches FULL, in_ready=0 and beat 3 is held upstream. Once out_ready=1, the outputs are 1, 2, 3 in order and in_ready returns to 1 one cycle after the first out_fire.
- Flush
  - Stimulus: FULL with ctrl 8'hFF in both slots; assert flush for 1 cycle.
  - Required: next cycle out_valid=0, out_ctrl=0, in_ready=1. A new beat is then accepted normally.
- Stall counter
  - Stimulus: out_valid=1 and out_ready=0 for 5 cycles.
  - Required: stall_cnt=5. With CNT_W=3 and 10 stall cycles, it saturates at 7. Pulsing cnt_clr gives 0.
- Reset mid-operation
  - Stimulus: arst_n=0 while FULL.
  - Required: on the next edge out_valid=0, in_ready=0, out_data=PRESET_VAL, stall_cnt=0.
